// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA scan-out engine.
//   rgb_t              24-bit {red, green, blue} colour
//   shadow_t           per-frame copy of the user controls (pan, zoom, cursor, palette)
//   LIVE_PAL / BG_PAL  palettes selected by color_id[1:0] / color_id[3:2]
//   GRID_RGB           grid-line colour (only used when VGA_GRID_EN is defined)
//   DEF_*              default 800x600 raster timing
package vga_pkg;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [15:0] shift_x;
        logic [15:0] shift_y;
        logic [3:0]  scroll;
        logic        cursor_en;
        logic [15:0] cursor_x;
        logic [15:0] cursor_y;
        logic [3:0]  color_id;
    } shadow_t;

    localparam rgb_t LIVE_PAL [4] = '{24'hFFFFFF, 24'h00FF00, 24'hFFFF00, 24'h00FFFF};
    localparam rgb_t BG_PAL   [4] = '{24'h101010, 24'h202020, 24'h000040, 24'h400000};
    localparam rgb_t GRID_RGB        = 24'h404040;
    localparam rgb_t CURSOR_LIVE_RGB = 24'hFF0000;
    localparam rgb_t CURSOR_DEAD_RGB = 24'h0000FF;

    localparam int DEF_HSIZE = 800;
    localparam int DEF_HFP   = 856;
    localparam int DEF_HSP   = 976;
    localparam int DEF_HMAX  = 1040;
    localparam int DEF_VSIZE = 600;
    localparam int DEF_VFP   = 637;
    localparam int DEF_VSP   = 643;
    localparam int DEF_VMAX  = 666;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters and undelayed sync / visible flags.
//   clk, rst_n         pixel clock, async active-low reset
//   hdata, vdata       current pixel column / row (stage 0)
//   hsync_raw, vsync_raw, de_raw  syncs and visible flag decoded from the counters
//   eof                high on the last pixel of the frame (hdata==HMAX-1, vdata==VMAX-1)
module vga_timing
    import vga_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int HSIZE = DEF_HSIZE,
    parameter int HFP   = DEF_HFP,
    parameter int HSP   = DEF_HSP,
    parameter int HMAX  = DEF_HMAX,
    parameter int VSIZE = DEF_VSIZE,
    parameter int VFP   = DEF_VFP,
    parameter int VSP   = DEF_VSP,
    parameter int VMAX  = DEF_VMAX,
    parameter int HSPP  = 1,
    parameter int VSPP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] hdata,
    output logic [WIDTH-1:0] vdata,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             de_raw,
    output logic             eof
);

    localparam logic HSPP_B = (HSPP != 0);
    localparam logic VSPP_B = (VSPP != 0);

    logic [WIDTH-1:0] hdata_q, hdata_d;
    logic [WIDTH-1:0] vdata_q, vdata_d;
    logic             h_last_s, v_last_s;

    assign h_last_s = (hdata_q == WIDTH'(HMAX - 1));
    assign v_last_s = (vdata_q == WIDTH'(VMAX - 1));

    // Next counter values: column wraps every line, row advances on column wrap.
    always_comb begin
        hdata_d = hdata_q;
        vdata_d = vdata_q;
        if (h_last_s) begin
            hdata_d = '0;
            if (v_last_s) begin
                vdata_d = '0;
            end else begin
                vdata_d = vdata_q + WIDTH'(1);
            end
        end else begin
            hdata_d = hdata_q + WIDTH'(1);
            vdata_d = vdata_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdata_q <= '0;
            vdata_q <= '0;
        end else begin
            hdata_q <= hdata_d;
            vdata_q <= vdata_d;
        end
    end

    assign hdata     = hdata_q;
    assign vdata     = vdata_q;
    assign hsync_raw = ((hdata_q >= WIDTH'(HFP)) && (hdata_q < WIDTH'(HSP))) ? HSPP_B : ~HSPP_B;
    assign vsync_raw = ((vdata_q >= WIDTH'(VFP)) && (vdata_q < WIDTH'(VSP))) ? VSPP_B : ~VSPP_B;
    assign de_raw    = (hdata_q < WIDTH'(HSIZE)) && (vdata_q < WIDTH'(VSIZE));
    assign eof       = h_last_s && v_last_s;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scan-out for the Life board with pan, power-of-two zoom and toroidal wrap.
//   clk, rst_n                      pixel clock, async active-low reset
//   shift_x/y, scroll               pan offset and zoom shift (sampled once per frame)
//   cursor_en, cursor_x/y           cursor cell highlight (sampled once per frame)
//   color_id                        [1:0] live palette, [3:2] background palette
//   rd_en, rd_addr, rd_data         board RAM read port, data returns RD_LAT cycles after rd_en
//   hsync, vsync, data_enable       syncs / visible flag, delayed to line up with the pixel
//   video_red/green/blue            pixel colour
//   frame_start                     one-cycle pulse when the shadow controls load
// Optional build macro VGA_GRID_EN: draws grid lines when zoomed by 4x or more.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int HSIZE      = DEF_HSIZE,
    parameter int HFP        = DEF_HFP,
    parameter int HSP        = DEF_HSP,
    parameter int HMAX       = DEF_HMAX,
    parameter int VSIZE      = DEF_VSIZE,
    parameter int VFP        = DEF_VFP,
    parameter int VSP        = DEF_VSP,
    parameter int VMAX       = DEF_VMAX,
    parameter int HSPP       = 1,
    parameter int VSPP       = 1,
    parameter int BOARD_N    = 256,
    parameter int BOARD_M    = 256,
    parameter int WORD_BITS  = 32,
    parameter int RD_LAT     = 2,
    parameter int MAX_SCROLL = 4,
    localparam int CX_W      = $clog2(BOARD_N),
    localparam int CY_W      = $clog2(BOARD_M),
    localparam int BIT_W     = $clog2(WORD_BITS),
    localparam int ADDR_W    = CX_W + CY_W - BIT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          shift_x,
    input  logic [15:0]          shift_y,
    input  logic [3:0]           scroll,
    input  logic                 cursor_en,
    input  logic [15:0]          cursor_x,
    input  logic [15:0]          cursor_y,
    input  logic [3:0]           color_id,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_BITS-1:0] rd_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 data_enable,
    output logic [7:0]           video_red,
    output logic [7:0]           video_green,
    output logic [7:0]           video_blue,
    output logic                 frame_start
);

    localparam logic HSPP_B = (HSPP != 0);
    localparam logic VSPP_B = (VSPP != 0);

    // Side information that travels alongside the memory read.
    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic [BIT_W-1:0] bit_idx;
        logic             cur;
`ifdef VGA_GRID_EN
        logic             grid;
`endif
    } pipe_t;

    logic [WIDTH-1:0] hdata_s, vdata_s;
    logic             hsync_raw_s, vsync_raw_s, de_raw_s, eof_s;

    vga_timing #(
        .WIDTH(WIDTH), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
        .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(HSPP), .VSPP(VSPP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .hdata     (hdata_s),
        .vdata     (vdata_s),
        .hsync_raw (hsync_raw_s),
        .vsync_raw (vsync_raw_s),
        .de_raw    (de_raw_s),
        .eof       (eof_s)
    );

    shadow_t shadow_q, shadow_d, shadow_in_s;
    logic    frame_start_q, frame_start_d;

    assign shadow_in_s = '{shift_x, shift_y, scroll, cursor_en, cursor_x, cursor_y, color_id};

    // Shadow controls only change on the frame boundary so a frame is never torn.
    always_comb begin
        if (eof_s) begin
            shadow_d = shadow_in_s;
        end else begin
            shadow_d = shadow_q;
        end
        frame_start_d = eof_s;
    end

    // Stage 1: zoomed, panned cell coordinates and the word/bit they live in.
    logic [3:0]         scroll_eff_s;
    logic [WIDTH-1:0]   hs_s, vs_s;
    logic [CX_W-1:0]    cx_s;
    logic [CY_W-1:0]    cy_s;
    logic [CX_W+CY_W-1:0] lin_s;
    pipe_t              stage1_s;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
`ifdef VGA_GRID_EN
    logic [WIDTH-1:0]   mask_s;
`endif

    // Address computation; wrap-around comes for free from truncating to the board size.
    always_comb begin
        scroll_eff_s = (shadow_q.scroll > 4'(MAX_SCROLL)) ? 4'(MAX_SCROLL) : shadow_q.scroll;
        hs_s         = hdata_s >> scroll_eff_s;
        vs_s         = vdata_s >> scroll_eff_s;
        cx_s         = CX_W'(16'(hs_s) + shadow_q.shift_x);
        cy_s         = CY_W'(16'(vs_s) + shadow_q.shift_y);
        lin_s        = {cy_s, cx_s};
        rd_en_d      = de_raw_s;
        rd_addr_d    = lin_s[CX_W+CY_W-1:BIT_W];
        stage1_s.de      = de_raw_s;
        stage1_s.hs      = hsync_raw_s;
        stage1_s.vs      = vsync_raw_s;
        stage1_s.bit_idx = lin_s[BIT_W-1:0];
        stage1_s.cur     = shadow_q.cursor_en && (16'(cx_s) == shadow_q.cursor_x)
                           && (16'(cy_s) == shadow_q.cursor_y);
`ifdef VGA_GRID_EN
        mask_s        = (WIDTH'(1) << scroll_eff_s) - WIDTH'(1);
        stage1_s.grid = (scroll_eff_s >= 4'd2)
                        && (((hdata_s & mask_s) == '0) || ((vdata_s & mask_s) == '0));
`endif
    end

    // pipe_q[0] is stage 1; pipe_q[RD_LAT] lines up with rd_data.
    pipe_t [RD_LAT:0] pipe_q, pipe_d;

    // Delay line shift.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = stage1_s;
        for (int i = 1; i <= RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    pipe_t tail_s;
    logic  live_s;
    rgb_t  rgb_q, rgb_d;
    logic  hsync_q, vsync_q, de_q;

    assign tail_s = pipe_q[RD_LAT];
    assign live_s = rd_data[tail_s.bit_idx];

    // Pixel colour: blank outside the visible area, cursor wins over everything else.
    always_comb begin
        rgb_d = '0;
        if (!tail_s.de) begin
            rgb_d = '0;
        end else if (tail_s.cur) begin
            rgb_d = live_s ? CURSOR_LIVE_RGB : CURSOR_DEAD_RGB;
`ifdef VGA_GRID_EN
        end else if (tail_s.grid) begin
            rgb_d = GRID_RGB;
`endif
        end else if (live_s) begin
            rgb_d = LIVE_PAL[shadow_q.color_id[1:0]];
        end else begin
            rgb_d = BG_PAL[shadow_q.color_id[3:2]];
        end
    end

    // All state registers; syncs reset to their inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            frame_start_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            pipe_q        <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_q[i].hs <= ~HSPP_B;
                pipe_q[i].vs <= ~VSPP_B;
            end
            rgb_q         <= '0;
            hsync_q       <= ~HSPP_B;
            vsync_q       <= ~VSPP_B;
            de_q          <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            pipe_q        <= pipe_d;
            rgb_q         <= rgb_d;
            hsync_q       <= tail_s.hs;
            vsync_q       <= tail_s.vs;
            de_q          <= tail_s.de;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign data_enable = de_q;
    assign video_red   = rgb_q[23:16];
    assign video_green = rgb_q[15:8];
    assign video_blue  = rgb_q[7:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (84x70 total, 64x64 visible)
// so several whole frames fit in a short run. cyc counts rising edges since reset
// release; the pixel at (x,y) of frame f appears on the outputs after edge
// f*5880 + y*84 + x + 4, and its read address after edge f*5880 + y*84 + x + 1.
module tb_vga_scanout;

    logic        clk;
    logic        rst_n;
    logic [15:0] shift_x, shift_y, cursor_x, cursor_y;
    logic [3:0]  scroll, color_id;
    logic        cursor_en;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [31:0] rd_data;
    logic        hsync, vsync, data_enable, frame_start;
    logic [7:0]  video_red, video_green, video_blue;
    logic [23:0] rgb;
    logic [1:0]  mem_mode;
    int          cyc;
    int          checks;
    int          errors;

    vga_scanout #(
        .WIDTH(12), .HSIZE(64), .HFP(70), .HSP(78), .HMAX(84),
        .VSIZE(64), .VFP(66), .VSP(68), .VMAX(70)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_x     (shift_x),
        .shift_y     (shift_y),
        .scroll      (scroll),
        .cursor_en   (cursor_en),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .color_id    (color_id),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .data_enable (data_enable),
        .video_red   (video_red),
        .video_green (video_green),
        .video_blue  (video_blue),
        .frame_start (frame_start)
    );

    assign rgb = {video_red, video_green, video_blue};

    // Board memory: every word all-dead, all-live, or only bit 0 live.
    always_comb begin
        case (mem_mode)
            2'd0:    rd_data = 32'h0000_0000;
            2'd1:    rd_data = 32'hFFFF_FFFF;
            default: rd_data = 32'h0000_0001;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge n.
    task automatic wait_cyc(input int n);
        if (cyc > n) begin
            checks++;
            errors++;
            $display("FAIL sequence cyc=%0d target=%0d", cyc, n);
        end
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        shift_x = 16'd0; shift_y = 16'd0; scroll = 4'd0; cursor_en = 1'b0;
        cursor_x = 16'd0; cursor_y = 16'd0; color_id = 4'd0; mem_mode = 2'd1;
        #2 rst_n = 1'b0;
        #20;
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h0);
        check("rst_vsync", 32'(vsync), 32'h0);
        check("rst_de", 32'(data_enable), 32'h0);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Frame 0: default shadows, all cells live.
        wait_cyc(1);
        check("f0_rd_en", 32'(rd_en), 32'h1);
        check("f0_rd_addr0", 32'(rd_addr), 32'h0);
        wait_cyc(3);
        check("f0_de_early", 32'(data_enable), 32'h0);
        wait_cyc(4);
        check("f0_de_first", 32'(data_enable), 32'h1);
        check("f0_rgb_first", 32'(rgb), 32'hFFFFFF);
        wait_cyc(67);
        check("f0_de_last", 32'(data_enable), 32'h1);
        wait_cyc(68);
        check("f0_de_off", 32'(data_enable), 32'h0);
        check("f0_rgb_blank", 32'(rgb), 32'h0);
        wait_cyc(73);
        check("hs_before", 32'(hsync), 32'h0);
        wait_cyc(74);
        check("hs_rise", 32'(hsync), 32'h1);
        wait_cyc(81);
        check("hs_last", 32'(hsync), 32'h1);
        wait_cyc(82);
        check("hs_fall", 32'(hsync), 32'h0);

        // Mid-frame control change must wait for the next frame.
        wait_cyc(2520);
        shift_x = 16'd255; shift_y = 16'd5; color_id = 4'b0110;
        wait_cyc(3361);
        check("f0_row40_addr", 32'(rd_addr), 32'd320);
        wait_cyc(3369);
        check("f0_row40_rgb", 32'(rgb), 32'hFFFFFF);
        wait_cyc(5000);
        mem_mode = 2'd2;
        wait_cyc(5547);
        check("vs_before", 32'(vsync), 32'h0);
        wait_cyc(5548);
        check("vs_rise", 32'(vsync), 32'h1);
        wait_cyc(5715);
        check("vs_last", 32'(vsync), 32'h1);
        wait_cyc(5716);
        check("vs_fall", 32'(vsync), 32'h0);
        wait_cyc(5879);
        check("fs_before", 32'(frame_start), 32'h0);

        // Frame 1: shift_x=255 wraps within the row, shift_y=5, palettes 2/1.
        wait_cyc(5880);
        check("fs_f1", 32'(frame_start), 32'h1);
        wait_cyc(5881);
        check("fs_after", 32'(frame_start), 32'h0);
        check("f1_addr_px0", 32'(rd_addr), 32'd47);
        wait_cyc(5882);
        check("f1_addr_px1", 32'(rd_addr), 32'd40);
        wait_cyc(5884);
        check("f1_rgb_px0_dead", 32'(rgb), 32'h202020);
        wait_cyc(5885);
        check("f1_rgb_px1_live", 32'(rgb), 32'hFFFF00);
        wait_cyc(5916);
        check("f1_rgb_px32_dead", 32'(rgb), 32'h202020);
        wait_cyc(5917);
        check("f1_rgb_px33_live", 32'(rgb), 32'hFFFF00);

        // Frame 2: scroll 7 clamps to 4, cursor at cell (2,3), all dead.
        wait_cyc(6000);
        shift_x = 16'd0; shift_y = 16'd0; scroll = 4'd7; cursor_en = 1'b1;
        cursor_x = 16'd2; cursor_y = 16'd3; color_id = 4'd0; mem_mode = 2'd0;
        wait_cyc(11760);
        check("fs_f2", 32'(frame_start), 32'h1);
        wait_cyc(15744);
        check("cur_above", 32'(rgb), 32'h101010);
        wait_cyc(15825);
        check("cur_addr", 32'(rd_addr), 32'd24);
        wait_cyc(15827);
        check("cur_left", 32'(rgb), 32'h101010);
        wait_cyc(15828);
        check("cur_tl", 32'(rgb), 32'h0000FF);
        wait_cyc(15843);
        check("cur_tr", 32'(rgb), 32'h0000FF);
        wait_cyc(15844);
        check("cur_right", 32'(rgb), 32'h101010);
        wait_cyc(16424);
        check("cur_mid", 32'(rgb), 32'h0000FF);
        wait_cyc(17103);
        check("cur_br", 32'(rgb), 32'h0000FF);

        // Reset pulse mid-line in frame 3 at hdata=50, vdata=10.
        wait_cyc(17200);
        mem_mode = 2'd1;
        wait_cyc(18530);
        check("pre_rst_de", 32'(data_enable), 32'h1);
        check("pre_rst_rgb", 32'(rgb), 32'hFFFFFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rgb", 32'(rgb), 32'h0);
        check("mid_rst_hsync", 32'(hsync), 32'h0);
        check("mid_rst_vsync", 32'(vsync), 32'h0);
        check("mid_rst_de", 32'(data_enable), 32'h0);
        check("mid_rst_rd_en", 32'(rd_en), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(1);
        check("rs_rd_en", 32'(rd_en), 32'h1);
        check("rs_rd_addr", 32'(rd_addr), 32'h0);
        wait_cyc(3);
        check("rs_de_early", 32'(data_enable), 32'h0);
        wait_cyc(4);
        check("rs_de_first", 32'(data_enable), 32'h1);
        check("rs_rgb_first", 32'(rgb), 32'hFFFFFF);
        wait_cyc(4068);
        check("rs_no_cursor", 32'(rgb), 32'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
